// File: rtl/fifo_umbral_if.sv
// Push/pop, threshold-programming and status bundle of one fifo_umbral lane.
// The FIFO connects through the slave modport; its user or driver connects through master.
interface fifo_umbral_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
);
  logic                  init;
  logic [ADDR_WIDTH-1:0] umbral_L;
  logic [ADDR_WIDTH-1:0] umbral_H;
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  error;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output init, umbral_L, umbral_H, push, data_in, pop,
    input  data_out, valid_out, empty, full, almost_empty, almost_full, error, count
  );

  modport slave (
    input  init, umbral_L, umbral_H, push, data_in, pop,
    output data_out, valid_out, empty, full, almost_empty, almost_full, error, count
  );
endinterface

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-empty/almost-full thresholds and a
// sticky overflow/underflow flag. Occupancy comes from count, never from pointer compare.
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic          clk,
  input  logic          reset,
  fifo_umbral_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q;
  logic [ADDR_WIDTH-1:0] umbral_l_q, umbral_h_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  error_q;

  logic          is_empty, is_full;
  logic          rd_en, wr_en;
  logic          overflow, underflow;
  logic [CW-1:0] af_level;

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CW'(DEPTH));
  assign rd_en     = bus.pop && !is_empty;
  // A pop in the same cycle frees a slot, so a push while full is still accepted.
  assign wr_en     = bus.push && (!is_full || rd_en);
  assign overflow  = bus.push && is_full && !bus.pop;
  assign underflow = bus.pop && is_empty;
  assign af_level  = CW'(DEPTH) - CW'(umbral_h_q);

  // NOTE: storage has no reset; stale words are unreachable because count gates every read.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_ptr] <= bus.data_in;
  end

  // NOTE: non-blocking assignments let the full-case pop read the old word
  // from the same slot the simultaneous push overwrites.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      umbral_l_q <= '0;
      umbral_h_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (bus.init) begin
        umbral_l_q <= bus.umbral_L;
        umbral_h_q <= bus.umbral_H;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= mem[rd_ptr];
      end
      valid_q <= rd_en;
      if (wr_en && !rd_en)      count_q <= count_q + 1'b1;
      else if (rd_en && !wr_en) count_q <= count_q - 1'b1;
      if (overflow || underflow) error_q <= 1'b1;
    end
  end

  assign bus.data_out     = data_q;
  assign bus.valid_out    = valid_q;
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_empty = (count_q <= CW'(umbral_l_q));
  assign bus.almost_full  = (count_q >= af_level);
  assign bus.error        = error_q;
  assign bus.count        = count_q;
endmodule
